bram_port_arbiter: RTL

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

---
 rtl/bram_port_arbiter_pkg.sv | 17 +
 rtl/bram_tag_pipe.sv | 39 +++
 rtl/bram_port_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the two-requester BRAM port arbiter.
// Parameter defaults and the requester tag format live here.
package bram_port_arbiter_pkg;

  localparam int ADDR_W_DEF  = 15;
  localparam int DATA_W_DEF  = 32;
  localparam int LATENCY_DEF = 2;
  localparam int ID_W        = 1;

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/bram_tag_pipe.sv
// Response tag shift register: one {valid, id} per BRAM latency stage.
// Synchronous clear drops every in-flight tag.
module bram_tag_pipe
  import bram_port_arbiter_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic clka,
  input  logic clr,
  input  tag_t in_tag,
  output tag_t out_tag,
  output logic pre_valid
);

  tag_t stage_q [LATENCY];

  always_ff @(posedge clka) begin
    if (clr) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_tag = stage_q[LATENCY-1];

  // With a single stage the "previous stage" is the tag being loaded.
  if (LATENCY == 1) begin : g_l1
    assign pre_valid = in_tag.valid;
  end else begin : g_ln
    assign pre_valid = stage_q[LATENCY-2].valid;
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one write-first BRAM port by two requesters.
// Every accepted request returns one response LATENCY cycles later.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic              clka,
  input  logic              rstb,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_regce,
  output logic              bram_rst,
  input  logic [DATA_W-1:0] bram_dout
);

  req_id_t    last_grant;
  logic [1:0] gnt;
  logic       accepted;
  req_id_t    gnt_id;
  tag_t       in_tag;
  tag_t       out_tag;
  logic       pre_valid;

  // Contention goes to the requester that did not win last.
  always_comb begin
    gnt = 2'b00;
    if (!rstb) begin
      unique case ({req1_valid, req0_valid})
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant[0] ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign accepted   = |gnt;
  assign gnt_id     = gnt[1];

  always_ff @(posedge clka) begin
    if (rstb) begin
      last_grant <= req_id_t'(1);
    end else if (accepted) begin
      last_grant <= gnt_id;
    end
  end

  assign bram_en   = accepted;
  assign bram_we   = accepted & (gnt[1] ? req1_we : req0_we);
  assign bram_addr = gnt[1] ? req1_addr : req0_addr;
  assign bram_din  = gnt[1] ? req1_wdata : req0_wdata;

  assign in_tag.valid = accepted;
  assign in_tag.id    = gnt_id;

  bram_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clka      (clka),
    .clr       (rstb),
    .in_tag    (in_tag),
    .out_tag   (out_tag),
    .pre_valid (pre_valid)
  );

  assign bram_regce = pre_valid;
  assign bram_rst   = rstb;

  // Reset is synchronous, so the final stage is masked while it is held.
  assign rsp0_valid = !rstb && out_tag.valid
                   && (out_tag.id == req_id_t'(0));
  assign rsp1_valid = !rstb && out_tag.valid
                   && (out_tag.id == req_id_t'(1));
  assign rsp0_rdata = bram_dout;
  assign rsp1_rdata = bram_dout;

endmodule
